// File: rtl/condicionador_pkg.sv
// Shared definitions for the button-conditioning stage.
//   estado_t         : FSM state encoding, also exported on db_estado
//   BOTOES_W         : number of push buttons
//   DEBOUNCE_PADRAO  : default debounce length in clock cycles
//   eh_one_hot()     : true when exactly one bit of a button pattern is set
package condicionador_pkg;

  localparam int unsigned BOTOES_W        = 4;
  localparam int unsigned DEBOUNCE_PADRAO = 5;

  typedef enum logic [2:0] {
    ESPERA         = 3'd0,
    FILTRA         = 3'd1,
    REGISTRA       = 3'd2,
    REJEITA        = 3'd3,
    AGUARDA_SOLTAR = 3'd4
  } estado_t;

  // x & (x-1) clears the lowest set bit, so zero result means at most one bit.
  function automatic logic eh_one_hot(input logic [BOTOES_W-1:0] x);
    return (x != '0) && ((x & (x - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Two-flop synchroniser for an asynchronous bus.
//   clock     : destination clock
//   reset     : synchronous, active-high; clears both stages
//   assincrono: raw asynchronous input levels
//   sincrono  : levels after two flops, safe to use in the clock domain
module sincronizador_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] assincrono,
  output logic [WIDTH-1:0] sincrono
);

  logic [WIDTH-1:0] estagio1;

  always_ff @(posedge clock) begin
    if (reset) begin
      estagio1 <= '0;
      sincrono <= '0;
    end else begin
      estagio1 <= assincrono;
      sincrono <= estagio1;
    end
  end

endmodule

// File: rtl/condicionador_botoes.sv
// Push-button conditioner: synchronises, debounces and validates presses,
// producing one one-hot play code and a single strobe per physical press.
//   clock      : system clock, rising edge
//   reset      : synchronous, active-high
//   botoes     : raw asynchronous button levels, active-high
//   jogada     : last accepted one-hot code, held until the next accepted press
//   tem_jogada : one-cycle strobe, jogada valid in the same cycle
//   multipla   : one-cycle strobe, a stable multi-button pattern was rejected
//   db_estado  : current FSM state code
module condicionador_botoes
  import condicionador_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_PADRAO
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [BOTOES_W-1:0] botoes,
  output logic [BOTOES_W-1:0] jogada,
  output logic                tem_jogada,
  output logic                multipla,
  output logic [2:0]          db_estado
);

  localparam logic [7:0] CONT_FIM = 8'(DEBOUNCE_CYCLES - 1);

  logic [BOTOES_W-1:0] botoes_s;
  logic [BOTOES_W-1:0] padrao;
  logic [7:0]          cont;
  estado_t             estado;

  sincronizador_2ff #(
    .WIDTH(BOTOES_W)
  ) u_sinc (
    .clock     (clock),
    .reset     (reset),
    .assincrono(botoes),
    .sincrono  (botoes_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= ESPERA;
      padrao <= '0;
      cont   <= '0;
      jogada <= '0;
    end else begin
      unique case (estado)
        ESPERA: begin
          if (botoes_s != '0) begin
            padrao <= botoes_s;
            cont   <= 8'd1;
            estado <= FILTRA;
          end
        end

        FILTRA: begin
          if (botoes_s == '0) begin
            estado <= ESPERA;
          end else if (botoes_s != padrao) begin
            // Pattern changed: restart filtering on the new pattern.
            padrao <= botoes_s;
            cont   <= 8'd1;
          end else if (cont != CONT_FIM) begin
            cont <= cont + 8'd1;
          end else if (eh_one_hot(padrao)) begin
            jogada <= padrao;
            estado <= REGISTRA;
          end else begin
            estado <= REJEITA;
          end
        end

        REGISTRA, REJEITA: begin
          cont   <= '0;
          estado <= AGUARDA_SOLTAR;
        end

        AGUARDA_SOLTAR: begin
          if (botoes_s != '0) begin
            cont <= '0;
          end else if (cont == CONT_FIM) begin
            estado <= ESPERA;
          end else begin
            cont <= cont + 8'd1;
          end
        end

        default: estado <= ESPERA;
      endcase
    end
  end

  assign tem_jogada = (estado == REGISTRA);
  assign multipla   = (estado == REJEITA);
  assign db_estado  = estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
module tb_condicionador_botoes;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] botoes;
  logic [3:0] jogada;
  logic       tem_jogada;
  logic       multipla;
  logic [2:0] db_estado;

  int errors = 0;
  int checks = 0;

  // Strobe bookkeeping updated every observed cycle.
  int   tem_cnt, mult_cnt, cyc_n, tem_cyc, mult_cyc;
  logic prev_strobe = 1'b0;

  typedef struct {
    logic [3:0] pat;
    int         hold;
    int         off;
    int         exp_tem;
    int         exp_mult;
    logic [3:0] exp_jog;
  } vetor_t;

  vetor_t vet[10];

  condicionador_botoes #(
    .DEBOUNCE_CYCLES(5)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .botoes    (botoes),
    .jogada    (jogada),
    .tem_jogada(tem_jogada),
    .multipla  (multipla),
    .db_estado (db_estado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nome, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nome, act, exp, $time);
    end
  endtask

  // One clock cycle; outputs are observed on the falling edge.
  task automatic cyc();
    @(negedge clock);
    cyc_n++;
    if (tem_jogada || multipla) begin
      chk("no_back_to_back_strobe", int'(prev_strobe), 0);
      chk("strobes_exclusive", int'(tem_jogada && multipla), 0);
    end
    if (tem_jogada) begin
      tem_cnt++;
      tem_cyc = cyc_n;
    end
    if (multipla) begin
      mult_cnt++;
      mult_cyc = cyc_n;
    end
    prev_strobe = tem_jogada || multipla;
  endtask

  task automatic clr();
    tem_cnt = 0; mult_cnt = 0; cyc_n = 0; tem_cyc = -1; mult_cyc = -1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    chk("rst_jogada", int'(jogada), 0);
    chk("rst_tem_jogada", int'(tem_jogada), 0);
    chk("rst_multipla", int'(multipla), 0);
    chk("rst_db_estado", int'(db_estado), 0);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    botoes = 4'b0000;
    clr();
    cycles(3);
    do_reset();
    cycles(2);

    // Exact latency: strobe in the 7th cycle after the first sampling edge.
    clr();
    botoes = 4'b0001;
    cycles(10);
    chk("lat_tem_cycle", tem_cyc, 7);
    chk("lat_tem_count", tem_cnt, 1);
    chk("lat_jogada", int'(jogada), 1);
    chk("lat_db_aguarda", int'(db_estado), 4);
    botoes = 4'b0000;
    cycles(10);
    chk("lat_db_espera", int'(db_estado), 0);

    vet[0] = '{4'b0001, 10, 10, 1, 0, 4'b0001};
    vet[1] = '{4'b0010,  3, 10, 0, 0, 4'b0001};  // too short
    vet[2] = '{4'b0101, 10, 10, 0, 1, 4'b0001};  // multi-hot
    vet[3] = '{4'b0100, 40, 10, 1, 0, 4'b0100};  // long hold
    vet[4] = '{4'b0001, 10, 10, 1, 0, 4'b0001};
    vet[5] = '{4'b0001, 10, 10, 1, 0, 4'b0001};
    vet[6] = '{4'b0010, 10, 10, 1, 0, 4'b0010};
    vet[7] = '{4'b1000,  5, 10, 1, 0, 4'b1000};  // minimum width
    vet[8] = '{4'b0100,  4, 10, 0, 0, 4'b1000};  // one short of minimum
    vet[9] = '{4'b1110, 10, 10, 0, 1, 4'b1000};

    foreach (vet[i]) begin
      clr();
      botoes = vet[i].pat;
      cycles(vet[i].hold);
      botoes = 4'b0000;
      cycles(vet[i].off);
      chk($sformatf("v%0d_tem", i), tem_cnt, vet[i].exp_tem);
      chk($sformatf("v%0d_mult", i), mult_cnt, vet[i].exp_mult);
      chk($sformatf("v%0d_jogada", i), int'(jogada), int'(vet[i].exp_jog));
      chk($sformatf("v%0d_db_estado", i), int'(db_estado), 0);
    end

    // Multi-hot rejection timing matches press acceptance timing.
    clr();
    botoes = 4'b0011;
    cycles(10);
    chk("mult_cycle", mult_cyc, 7);
    botoes = 4'b0000;
    cycles(10);

    // Pattern change restarts filtering; final stable pattern judged.
    clr();
    botoes = 4'b0001;
    cycles(3);
    botoes = 4'b0011;
    cycles(10);
    botoes = 4'b0000;
    cycles(10);
    chk("chg_tem", tem_cnt, 0);
    chk("chg_mult", mult_cnt, 1);
    chk("chg_jogada", int'(jogada), 8);

    // Bounce before stabilising: one strobe, after the stable period.
    clr();
    for (int i = 0; i < 6; i++) begin
      botoes = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      cyc();
    end
    botoes = 4'b0100;
    cycles(12);
    botoes = 4'b0000;
    cycles(10);
    chk("bounce_tem", tem_cnt, 1);
    chk("bounce_tem_cycle", tem_cyc, 13);
    chk("bounce_jogada", int'(jogada), 4);

    // Reset while filtering, button kept held: re-accepted after filtering.
    clr();
    botoes = 4'b0010;
    cycles(3);
    chk("filtra_db_estado", int'(db_estado), 1);
    do_reset();
    clr();
    cycles(10);
    chk("rst_f_tem_cycle", tem_cyc, 7);
    chk("rst_f_tem_count", tem_cnt, 1);
    chk("rst_f_jogada", int'(jogada), 2);
    chk("aguarda_db_estado", int'(db_estado), 4);

    // Reset while waiting for release, button still held.
    do_reset();
    clr();
    cycles(10);
    chk("rst_a_tem_cycle", tem_cyc, 7);
    chk("rst_a_jogada", int'(jogada), 2);
    botoes = 4'b0000;
    cycles(10);
    chk("end_db_estado", int'(db_estado), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/condicionador_botoes.md
# condicionador_botoes

Input-conditioning stage sitting directly upstream of the memory-game datapath/control unit. Synchronises the four raw push-button inputs, debounces them, rejects multi-button presses, and delivers exactly one registered one-hot code plus a single-cycle `tem_jogada` strobe per physical press. Release must be observed before the next press is accepted, so a held button never generates repeated plays.

## Interface
- `DEBOUNCE_CYCLES`, default 5: consecutive identical synchronised samples required to accept a press or a release; legal range 2..255.
- `clock`  in  1  system clock, 1 kHz nominal; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, single clock domain.
- `botoes`  in  4  raw asynchronous button levels, active-high.
- `jogada`  out  4  last accepted one-hot code; held until next accepted press.
- `tem_jogada`  out  1  one-cycle strobe; `jogada` is valid in the same cycle.
- `multipla`  out  1  one-cycle strobe: stable multi-hot pattern rejected.
- `db_estado`  out  3  current FSM state code, for debug display.

## Operation
- `botoes` passes through a 2-FF synchroniser → `botoes_s`. Only `botoes_s` is used downstream.
- Registers: `padrao` (4 b), `cont` (8 b, saturating never needed), `jogada` (4 b), state.
- States, codes: ESPERA=0, FILTRA=1, REGISTRA=2, REJEITA=3, AGUARDA_SOLTAR=4.
- ESPERA: `botoes_s`=0 → stay. Nonzero → `padrao`←`botoes_s`, `cont`←1, go FILTRA.
- FILTRA: `botoes_s`=0 → ESPERA (press too short, ignored). `botoes_s`≠`padrao`, nonzero → `padrao`←`botoes_s`, `cont`←1, stay. Equal and `cont`<`DEBOUNCE_CYCLES`-1 → `cont`++. Equal and `cont`=`DEBOUNCE_CYCLES`-1 → REGISTRA if `padrao` one-hot, else REJEITA.
- REGISTRA (one cycle): `tem_jogada`=1; `jogada` was loaded with `padrao` on the entering edge. Next → AGUARDA_SOLTAR, `cont`←0.
- REJEITA (one cycle): `multipla`=1; `jogada` unchanged. Next → AGUARDA_SOLTAR, `cont`←0.
- AGUARDA_SOLTAR: `botoes_s`≠0 → `cont`←0. `botoes_s`=0 → `cont`++; on the `DEBOUNCE_CYCLES`-th consecutive zero sample → ESPERA.
- Strobes are Moore outputs decoded from state; never high two cycles in a row.
- Reset mid-operation: state ESPERA, `padrao`, `cont`, `jogada`, synchroniser FFs all cleared; a button still held after reset is treated as a new press once filtered.
- Pattern change (e.g. 0001→0011) restarts filtering; only the final stable pattern is judged.

## Timing
- Reset values: `jogada`=0000, `tem_jogada`=0, `multipla`=0, `db_estado`=000.
- Let E0 be the first rising edge sampling a new level. Synchroniser: `botoes_s` valid after E1; FSM reacts at E2.
- Press accepted: REGISTRA entered at E(`DEBOUNCE_CYCLES`+1); `tem_jogada` high for the cycle following that edge. Default: strobe in the 7th cycle after E0.
- Minimum accepted press width: `DEBOUNCE_CYCLES` clocks; shorter pulses produce no strobe.
- Release: ESPERA re-entered `DEBOUNCE_CYCLES`+1 edges after the level drops (plus REGISTRA/REJEITA cycle if release overlaps it).
- Minimum press-to-press spacing for two strobes: press width + release width + 2 synchroniser cycles.

## Structure
- Package `condicionador_pkg`: state encodings (3-bit constants), default `DEBOUNCE_CYCLES`, `BOTOES_W`=4.
- Sub-module `sincronizador_2ff` (parameter width, synchronous reset to 0), instantiated once for the 4-bit bus; FSM, counter and output registers in the top.
- One-hot check: `padrao`≠0 and (`padrao` & (`padrao`−1))=0.

## Test plan
- Reset then `botoes`=0001 held 10 clocks → exactly one `tem_jogada` pulse, 7th cycle after first sampling edge; `jogada`=0001 held afterwards.
- `botoes`=0010 held 3 clocks → no strobe, state returns ESPERA, `jogada` unchanged.
- `botoes`=0101 held 10 clocks → one `multipla` pulse, no `tem_jogada`, `jogada` unchanged.
- `botoes`=0100 held 40 clocks → single strobe only; bounce 0100/0000 alternating each clock for 6 clocks before stable → one strobe after stabilisation.
- Sequence 0001,0001,0010 (10 on, 10 off each, as game bench) → three strobes, `jogada` 0001,0001,0010 in order.
- `reset` asserted in FILTRA and in AGUARDA_SOLTAR → all outputs zero next cycle, `db_estado`=000; held button re-accepted after filtering.
